// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: elastic pipeline stage with DEPTH-entry skid FIFO and exception merge.
// Optional back-pressure counter on stall_cnt when PIPE_STALL_CNT_EN is defined.
module pipe_stage_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 2,
  parameter int EXC_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_exc,
  input  logic [EXC_W-1:0]           in_exccode,
  input  logic [31:0]                in_badvaddr,
  input  logic                       loc_exc,
  input  logic [EXC_W-1:0]           loc_exccode,
  input  logic [31:0]                loc_badvaddr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_exc,
  output logic [EXC_W-1:0]           out_exccode,
  output logic [31:0]                out_badvaddr,
`ifdef PIPE_STALL_CNT_EN
  output logic [31:0]                stall_cnt,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              exc;
    logic [EXC_W-1:0]  code;
    logic [31:0]       bad;
  } entry_t;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  entry_t        ent, head;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq, deq;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign in_ready     = count_q < CW'(DEPTH);
  assign out_valid    = count_q != '0;
  assign head         = mem_q[head_q];
  assign out_data     = head.data;
  assign out_exc      = out_valid & head.exc;
  assign out_exccode  = head.code;
  assign out_badvaddr = head.bad;
  assign count        = count_q;
  assign enq          = in_valid & in_ready;
  assign deq          = out_valid & out_ready;
  always_comb begin
    ent.data = in_data;
    ent.exc  = in_exc | loc_exc;
    ent.code = in_exc ? in_exccode : loc_exc ? loc_exccode : '0;
    ent.bad  = in_exc ? in_badvaddr : loc_exc ? loc_badvaddr : '0;
    mem_d    = mem_q;
    if (enq && !flush) mem_d[tail_q] = ent;
    head_d   = flush ? '0 : deq ? inc(head_q) : head_q;
    tail_d   = flush ? '0 : enq ? inc(tail_q) : tail_q;
    count_d  = flush ? '0 : count_q + CW'(enq) - CW'(deq);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mem_q   <= '{default: '0};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  assign stall_cnt = stall_q;
  // saturating; flush deliberately leaves it alone
  assign stall_d = (out_valid && !out_ready && !(&stall_q)) ? stall_q + 32'd1 : stall_q;
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else stall_q <= stall_d;
  end
`endif
endmodule

// File: doc/pipe_stage_fifo.md
# pipe_stage_fifo

Parametrised successor to the fixed per-stage pipeline registers: one elastic stage register with a valid/ready handshake, a DEPTH-entry skid FIFO, and stage-local exception merging. It carries a packed payload plus exception code and bad address, so IF/ID/EX/MEM boundaries can use one block in place of hand-written flop lists. Flush and reset clear the stage. An optional stall counter supports performance debug.

## Interface
- DATA_W, 128: payload width in bits (≥1).
- DEPTH, 2: FIFO entries (1..4); DEPTH≥2 gives full throughput.
- EXC_W, 5: exception code width.
- Clock and reset are `clk` (one clock) and `rst`. `rst` is synchronous and active-high.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discard all held entries.
- in_valid  in  1  upstream has an entry.
- in_ready  out  1  stage can accept (allow-in).
- in_data  in  DATA_W  payload.
- in_exc  in  1  upstream exception flag.
- in_exccode  in  EXC_W  upstream exception code.
- in_badvaddr  in  32  upstream bad address.
- loc_exc  in  1  exception detected at this boundary (e.g. Ov, AdEL, AdES).
- loc_exccode  in  EXC_W  local exception code.
- loc_badvaddr  in  32  local bad address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  head payload.
- out_exc  out  1  head exception flag.
- out_exccode  out  EXC_W  head code.
- out_badvaddr  out  32  head bad address.
- count  out  $clog2(DEPTH+1)  entries held.
- stall_cnt  out  32  back-pressure cycles. Present only with PIPE_STALL_CNT_EN.

## Operation
- Storage is a circular buffer of DEPTH entries. Each entry holds {data, exc, exccode, badvaddr}. Head and tail pointers wrap modulo DEPTH.
- Enqueue happens when in_valid & in_ready. Dequeue happens when out_valid & out_ready. Both may occur in the same cycle; count is then unchanged and both pointers advance.
- in_ready = (count < DEPTH). It comes from registered state only, so there is no combinational path from out_ready.
- out_valid = (count != 0).
- out_data, out_exccode and out_badvaddr come from the head entry.
- out_exc = out_valid & head.exc, so an invalid output never signals an exception.
- Exception merge is applied at enqueue, in this priority order:
  - in_exc=1: store exc=1, in_exccode, in_badvaddr. Upstream wins; local is ignored.
  - else loc_exc=1: store exc=1, loc_exccode, loc_badvaddr.
  - else: store exc=0, code=0, badvaddr=0.
- Payload is always stored, including for excepting entries.
- Flush: count, head and tail are set to 0. A same-cycle enqueue or dequeue is ignored. Flush takes priority over the handshake. Storage contents are not cleared by flush.
- Reset: same as flush, and additionally all storage is zeroed. rst has priority over flush.

## Timing
- Latency: an entry enqueued at edge N is visible with out_valid=1 after edge N.
- Throughput:
  - DEPTH≥2: one entry per cycle with out_ready held high.
  - DEPTH=1: one entry every 2 cycles.
- Full (count==DEPTH): in_ready=0 in that cycle. in_ready returns to 1 the cycle after a dequeue.
- Empty: out_valid=0. Outputs are stale-but-gated: out_exc=0.
- Reset values: out_valid=0, in_ready=1, count=0, out_data=0, out_exc=0, out_exccode=0, out_badvaddr=0, stall_cnt=0.
- Flush mid-stream: the cycle after flush, out_valid=0 and in_ready=1, regardless of prior state.

## Configuration
- PIPE_STALL_CNT_EN defined: the stall_cnt port exists.
  - Increments when out_valid & !out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared only by rst, not by flush.
- PIPE_STALL_CNT_EN undefined: the port and counter are absent. Handshake behaviour is identical.

## Test plan
- Reset, then idle: out_valid=0, in_ready=1, count=0, out_data=0, out_exc=0.
- DEPTH=2, out_ready=1, stream data 1,2,3,4 on consecutive cycles: out_data 1,2,3,4 on consecutive cycles, starting one cycle after the first enqueue. in_ready stays 1.
- DEPTH=2, out_ready=0, push 0xA, 0xB, 0xC: count reaches 2 and in_ready=0. 0xC is held upstream. Raise out_ready: outputs 0xA, 0xB, 0xC in order. Pointers wrap correctly.
- Exception merge:
  - in_exc=1 (code 4, badvaddr 0x100) with loc_exc=1 (code 12): stored code 4, badvaddr 0x100.
  - Next entry with in_exc=0, loc_exc=1 (code 5, badvaddr 0x203): stored code 5, badvaddr 0x203.
- Full FIFO with flush=1 and in_valid=1 in the same cycle: next cycle count=0, out_valid=0, out_exc=0, in_ready=1. The flushed-cycle input is not stored.
- With PIPE_STALL_CNT_EN: hold out_valid=1, out_ready=0 for 7 cycles: stall_cnt=7. Then flush: stall_cnt stays 7. Then rst: stall_cnt=0.
